draw_scheduler: RTL and testbench

- Arbitrates the single framebuffer write port between up to NUM_REQ draw engines (cell drawer, cursor drawer, overlay/message drawer).
- Sequences whole draw jobs: a granted engine owns the port until it signals done, with one idle gap cycle between owners.
- Sits between the draw engines and the screen-memory write interface, replacing ad-hoc state-based muxing with a req/grant/done handshake, round-robin fairness and a hang watchdog.

---
 rtl/draw_scheduler.sv | 169 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Round-robin owner of the framebuffer write port for the draw engines.
// Ports: clk, rst; per-engine req/done/req_pos/req_color/req_wen and err_clr in;
//        grant, write_pos, write_data, write_en, busy, active_id, timeout_err out.
module draw_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int POS_W   = 19,
  parameter int COLOR_W = 3,
  parameter int TIMEOUT = 8192
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ*POS_W-1:0]   req_pos,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  input  logic [NUM_REQ-1:0]         req_wen,
  input  logic                       err_clr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [POS_W-1:0]           write_pos,
  output logic [COLOR_W-1:0]         write_data,
  output logic                       write_en,
  output logic                       busy,
  output logic [2:0]                 active_id,
  output logic                       timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_REL
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]      rr_q;
  logic [WD_W-1:0] wd_q;

  logic [3:0]      cand;
  logic [2:0]      sel;
  logic            sel_vld;
  logic [2:0]      sel_nxt;

  logic               own_req;
  logic               own_done;
  logic               own_wen;
  logic [POS_W-1:0]   own_pos;
  logic [COLOR_W-1:0] own_color;

  logic wd_hit;
  logic rel;

  // Scan from rr_q upward with wrap; the lowest offset that
  // requests wins, so iterate offsets high-to-low.
  always_comb begin
    cand    = '0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == 4'(i) && req[i]) begin
          sel     = 3'(i);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign sel_nxt = (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;

  // Only the owner's lanes are ever looked at.
  always_comb begin
    own_req   = 1'b0;
    own_done  = 1'b0;
    own_wen   = 1'b0;
    own_pos   = '0;
    own_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active_id == 3'(i)) begin
        own_req   = req[i];
        own_done  = done[i];
        own_wen   = req_wen[i];
        own_pos   = req_pos[i*POS_W +: POS_W];
        own_color = req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign wd_hit = (wd_q == WD_W'(TIMEOUT - 1));
  // Dropping req mid-job counts as done.
  assign rel    = own_done | ~own_req | wd_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (rel) begin
          state_d = S_REL;
        end
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      rr_q        <= '0;
      wd_q        <= '0;
      grant       <= '0;
      active_id   <= '0;
      write_en    <= 1'b0;
      write_pos   <= '0;
      write_data  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d != S_IDLE);
      write_en <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            grant     <= NUM_REQ'(1) << sel;
            active_id <= sel;
            rr_q      <= sel_nxt;
            wd_q      <= '0;
          end
        end
        S_OWN: begin
          // The pixel sampled on the release edge is still written.
          write_en   <= own_wen;
          write_pos  <= own_pos;
          write_data <= own_color;
          if (rel) begin
            grant <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
      // A timeout on the same edge as err_clr keeps the flag set.
      if (state_q == S_OWN && wd_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_draw_scheduler;

  localparam int N  = 3;
  localparam int PW = 19;
  localparam int CW = 3;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N*PW-1:0] req_pos;
  logic [N*CW-1:0] req_color;
  logic [N-1:0]    req_wen;
  logic            err_clr;
  logic [N-1:0]    grant;
  logic [PW-1:0]   write_pos;
  logic [CW-1:0]   write_data;
  logic            write_en;
  logic            busy;
  logic [2:0]      active_id;
  logic            timeout_err;

  int n_cmp;
  int n_bad;

  int          m_phase;
  int          m_owner;
  int          m_rr;
  int          m_wd;
  logic [N-1:0]  m_grant;
  logic          m_wen;
  logic [PW-1:0] m_pos;
  logic [CW-1:0] m_col;
  logic          m_busy;
  logic          m_err;

  draw_scheduler #(
    .NUM_REQ(N),
    .POS_W(PW),
    .COLOR_W(CW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .req_pos(req_pos),
    .req_color(req_color),
    .req_wen(req_wen),
    .err_clr(err_clr),
    .grant(grant),
    .write_pos(write_pos),
    .write_data(write_data),
    .write_en(write_en),
    .busy(busy),
    .active_id(active_id),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_rr    = 0;
    m_wd    = 0;
    m_grant = '0;
    m_wen   = 1'b0;
    m_pos   = '0;
    m_col   = '0;
    m_busy  = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock edge of the scheduling rules, from the current inputs.
  task automatic model_step();
    int  sel;
    bit  tmo;
    bit  rel;
    sel = -1;
    tmo = 1'b0;
    if (m_phase == 0) begin
      m_wen = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && req[(m_rr + k) % N]) sel = (m_rr + k) % N;
      end
      if (sel >= 0) begin
        m_grant = '0;
        m_grant[sel] = 1'b1;
        m_owner = sel;
        m_rr    = (sel + 1) % N;
        m_wd    = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_wen = req_wen[m_owner];
      m_pos = req_pos[m_owner*PW +: PW];
      m_col = req_color[m_owner*CW +: CW];
      tmo = (m_wd == TO - 1);
      rel = done[m_owner] || !req[m_owner] || tmo;
      if (rel) begin
        m_grant = '0;
        m_phase = 2;
      end else begin
        m_wd++;
      end
    end else begin
      m_wen   = 1'b0;
      m_phase = 0;
    end
    if (tmo) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_busy = (m_phase != 0);
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req       = '0;
    done      = '0;
    req_wen   = '0;
    req_pos   = '0;
    req_color = '0;
    err_clr   = 1'b0;
  endtask

  task automatic set_pix(int e, logic w, int p, int c);
    req_wen[e]            = w;
    req_pos[e*PW +: PW]   = PW'(p);
    req_color[e*CW +: CW] = CW'(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    n_cmp++;
    if ({grant, write_en, write_pos, write_data, busy, active_id, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got grant=%b we=%b pos=%0d data=%0d busy=%b id=%0d err=%b, want all zero",
               grant, write_en, write_pos, write_data, busy, active_id, timeout_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010;
    tick();
    n_cmp++;
    if (grant !== 3'b010 || busy !== 1'b1 || active_id !== 3'd1) begin
      n_bad++;
      $display("FAIL single_grant: grant=%b busy=%b id=%0d, want 010 1 1", grant, busy, active_id);
    end
    tick();
    set_pix(1, 1'b1, 100, 5);
    tick();
    n_cmp++;
    if (write_en !== 1'b1 || write_pos !== 19'd100 || write_data !== 3'd5) begin
      n_bad++;
      $display("FAIL single_pixel: we=%b pos=%0d data=%0d, want 1 100 5", write_en, write_pos, write_data);
    end
    set_pix(1, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    done = 3'b010;
    tick();
    done = '0;
    req  = '0;
    n_cmp++;
    if (grant !== 3'b000 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_release: grant=%b busy=%b, want 000 1", grant, busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || grant !== 3'b000) begin
      n_bad++;
      $display("FAIL single_idle: busy=%b grant=%b, want 0 000", busy, grant);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp;
    do_reset();
    for (int e = 0; e < N; e++) set_pix(e, 1'b1, 10 + e, e + 1);
    req = 3'b111;
    tick();
    for (int j = 0; j < 4; j++) begin
      exp = '0;
      exp[j % N] = 1'b1;
      n_cmp++;
      if (grant !== exp) begin
        n_bad++;
        $display("FAIL rr_order job%0d: grant=%b, want %b", j, grant, exp);
      end
      tick();
      n_cmp++;
      if (write_en !== 1'b1 || write_pos !== PW'(10 + j % N) || write_data !== CW'(j % N + 1)) begin
        n_bad++;
        $display("FAIL rr_pixel job%0d: we=%b pos=%0d data=%0d, want 1 %0d %0d",
                 j, write_en, write_pos, write_data, 10 + j % N, j % N + 1);
      end
      tick();
      tick();
      done = exp;
      tick();
      done = '0;
      n_cmp++;
      if (grant !== 3'b000 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_release job%0d: grant=%b busy=%b, want 000 1", j, grant, busy);
      end
      tick();
      n_cmp++;
      if (write_en !== 1'b0 || grant !== 3'b000 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_gap job%0d: we=%b grant=%b busy=%b, want 0 000 0", j, write_en, grant, busy);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b100;
    tick();
    n_cmp++;
    if (grant !== 3'b100) begin
      n_bad++;
      $display("FAIL tmo_grant: grant=%b, want 100", grant);
    end
    for (int i = 0; i < TO - 1; i++) tick();
    n_cmp++;
    if (grant !== 3'b100 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early: grant=%b err=%b, want 100 0", grant, timeout_err);
    end
    tick();
    req = '0;
    n_cmp++;
    if (grant !== 3'b000 || timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_fire: grant=%b err=%b, want 000 1", grant, timeout_err);
    end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_sticky: err=%b, want 1", timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_clear: err=%b, want 0", timeout_err);
    end
  endtask

  task automatic test_release_pixel();
    do_reset();
    req = 3'b001;
    tick();
    set_pix(0, 1'b1, 7, 2);
    done = 3'b001;
    tick();
    n_cmp++;
    if (grant !== 3'b000 || write_en !== 1'b1 || write_pos !== 19'd7 || write_data !== 3'd2) begin
      n_bad++;
      $display("FAIL rel_pixel: grant=%b we=%b pos=%0d data=%0d, want 000 1 7 2",
               grant, write_en, write_pos, write_data);
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (write_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_after: we=%b, want 0", write_en);
    end
  endtask

  task automatic test_noise();
    do_reset();
    req = 3'b011;
    tick();
    n_cmp++;
    if (grant !== 3'b001) begin
      n_bad++;
      $display("FAIL noise_grant: grant=%b, want 001", grant);
    end
    for (int i = 0; i < 4; i++) begin
      done = 3'b010;
      set_pix(1, 1'b1, 55, 6);
      set_pix(0, 1'b1, 3, 1);
      tick();
      n_cmp++;
      if (grant !== 3'b001 || write_pos !== 19'd3 || write_data !== 3'd1) begin
        n_bad++;
        $display("FAIL noise_cyc%0d: grant=%b pos=%0d data=%0d, want 001 3 1",
                 i, grant, write_pos, write_data);
      end
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b001;
    tick();
    set_pix(0, 1'b1, 9, 1);
    tick();
    n_cmp++;
    if (write_en !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: we=%b busy=%b, want 1 1", write_en, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (grant !== 3'b000 || write_en !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: grant=%b we=%b busy=%b, want 000 0 0", grant, write_en, busy);
    end
    #1 rst = 1'b0;
    clear_inputs();
    model_reset();
    req = 3'b100;
    tick();
    n_cmp++;
    if (grant !== 3'b100) begin
      n_bad++;
      $display("FAIL midrst_regrant: grant=%b, want 100", grant);
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int e = 0; e < N; e++) begin
        if ($urandom_range(9) == 0) req[e] = ~req[e];
        done[e] = ($urandom_range(7) == 0);
        set_pix(e, 1'($urandom_range(1)), int'($urandom_range(524287)), int'($urandom_range(7)));
      end
      err_clr = ($urandom_range(15) == 0);
      tick();
      n_cmp++;
      if (grant !== m_grant || busy !== m_busy || active_id !== 3'(m_owner)) begin
        n_bad++;
        $display("FAIL rnd_ctrl cyc%0d: grant=%b busy=%b id=%0d, want %b %b %0d",
                 c, grant, busy, active_id, m_grant, m_busy, m_owner);
      end
      n_cmp++;
      if (write_en !== m_wen || write_pos !== m_pos || write_data !== m_col) begin
        n_bad++;
        $display("FAIL rnd_write cyc%0d: we=%b pos=%0d data=%0d, want %b %0d %0d",
                 c, write_en, write_pos, write_data, m_wen, m_pos, m_col);
      end
      n_cmp++;
      if (timeout_err !== m_err) begin
        n_bad++;
        $display("FAIL rnd_err cyc%0d: err=%b, want %b", c, timeout_err, m_err);
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_release_pixel();
    test_noise();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
